calendar_display_driver: RTL and testbench
==========================================

// Module: calendar_display_driver
// PURPOSE
//  Consumes binary time/date fields from the calendar counter and drives an 8-digit multiplexed
//  common-anode 7-segment display. Periodically snapshots all fields coherently and converts
//  them to BCD with one shared sequential double-dabble engine. Scans digits one at a time.
//  Shows either the time page or the date page.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles each digit stays lit (>=2)
//  UPD_DIV    1000000 clk cycles between snapshots (>=128)
//  YEAR_BASE  2024   value added to year_bin before display
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, asynchronous, active-low
//  sec_bin     in   6   seconds 0..59
//  min_bin     in   6   minutes 0..59
//  hour_bin    in   5   hours 0..23
//  day_bin     in   5   day index 0..30 (displayed +1)
//  month_bin   in   4   month index 0..11 (displayed +1)
//  year_bin    in   14  year offset (displayed YEAR_BASE+year_bin, low 4 digits)
//  page_sel    in   1   0=time page, 1=date page; sampled at snapshot
//  seg_n       out  7   {g,f,e,d,c,b,a}, active-low
//  dp_n        out  1   decimal point, active-low
//  an_n        out  8   digit enables, an_n[7]=leftmost, active-low
//  busy        out  1   conversion in progress
// BEHAVIOUR
//  Reset: seg_n=7'h7F, dp_n=1, an_n=8'hFF, busy=0, all BCD regs 0, valid=0, counters 0.
//  Snapshot: at 1st clk after reset release, then each time upd_cnt reaches UPD_DIV-1.
//   - Latch all inputs and page_sel; busy=1 from next cycle.
//  Engine FSM: IDLE -> LOAD -> SHIFT(15 cycles) -> next field, or COMMIT -> IDLE.
//   - Field order: sec, min, hour, day+1, month+1, YEAR_BASE+year (15-bit sum, 5 BCD digits).
//   - Each field takes 16 cycles (1 load + 15 shifts, add-3 when nibble>=5 before shift).
//   - COMMIT occurs 96 cycles after latch: BCD display regs and page_active update together.
//   - busy=0 and valid=1 on COMMIT. Display never shows a partial mix of fields.
//  Input changes after the latch cycle have no effect until the next snapshot.
//  Range check at latch: sec>59, min>59, hour>23, day>30 or month>11 -> that field's two
//   digits show '-' (7'b0111111). Year is never out of range.
//   - Year display = (YEAR_BASE+year_bin) mod 10000; the 5th BCD digit is dropped.
//  Scanner: scan_cnt counts 0..SCAN_DIV-1. On wrap, digit idx increments 0..7 and wraps.
//   - Digit idx d drives an_n[d]=0, all other bits 1.
//   - an_n, seg_n and dp_n are registered and change in the same cycle.
//  While valid=0: an_n=8'hFF, seg_n=7'h7F, dp_n=1.
//  Time page: digits 7,6 blank (an_n bit stays 1); 5-4 HH, 3-2 MM, 1-0 SS; dp_n=0 on 4 and 2.
//  Date page: 7-6 DD, 5-4 MM, 3-0 YYYY; dp_n=0 on digits 6 and 4.
//  Glyphs: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, seg_n), blank=7F.
//  Simultaneous snapshot trigger while busy cannot occur (UPD_DIV>=128); if it does, ignore it.
//  Reset mid-conversion aborts everything immediately, returns to reset values, and valid=0.
// TESTING
//  (Benches use SCAN_DIV=4, UPD_DIV=256.)
//  1. Reset release -> an_n=FF, busy=1 for 96 cycles; after COMMIT, digit 0 lights within 4 cycles.
//  2. sec=45,min=7,hour=23,page=0 -> d0=12,d1=19,d2=78(dp0),d3=40,d4=30(dp0),d5=24; d6,d7 dark.
//  3. day=0,month=0,year=0,page=1 -> "01.01.2024": d7=40,d6=79(dp0),d5=40,d4=79(dp0),
//     d3..d0=24,40,24,19.
//  4. year=16383,page=1 -> 18407 mod 10000: d3..d0 = 8,4,0,7 (00,19,40,78).
//  5. sec=60,hour=24 -> d1,d0 and d5,d4 show 3F; min digits are correct.
//  6. Change inputs while busy=1 -> display shows latched values; the new values appear after
//     the next snapshot. Assert rst_n mid-SHIFT -> an_n=FF at once, then clean restart.

Source files
------------

// File: rtl/calendar_display_driver.sv
// Coherent snapshot of calendar fields, shared sequential double-dabble BCD engine,
// and an 8-digit multiplexed common-anode 7-segment scanner (time or date page).
module calendar_display_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned UPD_DIV   = 1000000,
  parameter int unsigned YEAR_BASE = 2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  sec_bin,
  input  logic [5:0]  min_bin,
  input  logic [4:0]  hour_bin,
  input  logic [4:0]  day_bin,
  input  logic [3:0]  month_bin,
  input  logic [13:0] year_bin,
  input  logic        page_sel,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        busy
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned UPD_W  = $clog2(UPD_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'(UPD_DIV - 1);
  localparam logic [14:0]       YEAR_OFS  = 15'(YEAR_BASE);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t            state;
  logic              started;
  logic [UPD_W-1:0]  upd_cnt;
  logic              snap_req;

  logic [5:0]  s_min;
  logic [4:0]  s_hour;
  logic [4:0]  s_day;
  logic [3:0]  s_mon;
  logic [13:0] s_year;
  logic        s_page;
  logic [4:0]  s_bad;

  logic [2:0]  field;
  logic [3:0]  step;
  logic [14:0] dd_bin;
  logic [19:0] dd_bcd;
  logic [15:0] adj;
  logic [2:0]  adj_top;
  logic [19:0] bcd_next;
  logic [14:0] load_val;

  logic [7:0]  stage_sec, stage_min, stage_hour, stage_day, stage_mon;
  logic [15:0] stage_year;
  logic [7:0]  disp_sec, disp_min, disp_hour, disp_day, disp_mon;
  logic [15:0] disp_year;
  logic [4:0]  disp_bad;
  logic        disp_page;
  logic        valid;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit;
  logic              dig_en, dig_bad, dig_dp;
  logic [3:0]        dig_val;
  logic [6:0]        seg_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      upd_cnt <= '0;
    end else begin
      started <= 1'b1;
      upd_cnt <= (upd_cnt == UPD_LAST) ? '0 : upd_cnt + UPD_W'(1);
    end
  end

  assign snap_req = !started || (upd_cnt == UPD_LAST);

  always_comb begin
    load_val = YEAR_OFS + 15'(s_year);
    case (field)
      3'd1:    load_val = 15'(s_min);
      3'd2:    load_val = 15'(s_hour);
      3'd3:    load_val = 15'(s_day) + 15'd1;
      3'd4:    load_val = 15'(s_mon) + 15'd1;
      default: ;
    endcase
  end

  // The top nibble only needs its low 3 bits adjusted: its MSB is shifted out.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (dd_bcd[4*i +: 4] >= 4'd5) ? dd_bcd[4*i +: 4] + 4'd3 : dd_bcd[4*i +: 4];
    end
    adj_top  = dd_bcd[18:16] + ((dd_bcd[19:16] >= 4'd5) ? 3'd3 : 3'd0);
    bcd_next = {adj_top, adj, dd_bin[14]};
  end

  // The latch cycle doubles as the seconds load so a full pass is exactly 6 x 16 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      field      <= '0;
      step       <= '0;
      dd_bin     <= '0;
      dd_bcd     <= '0;
      s_min      <= '0;
      s_hour     <= '0;
      s_day      <= '0;
      s_mon      <= '0;
      s_year     <= '0;
      s_page     <= 1'b0;
      s_bad      <= '0;
      stage_sec  <= '0;
      stage_min  <= '0;
      stage_hour <= '0;
      stage_day  <= '0;
      stage_mon  <= '0;
      stage_year <= '0;
      disp_sec   <= '0;
      disp_min   <= '0;
      disp_hour  <= '0;
      disp_day   <= '0;
      disp_mon   <= '0;
      disp_year  <= '0;
      disp_bad   <= '0;
      disp_page  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (snap_req) begin
          s_min  <= min_bin;
          s_hour <= hour_bin;
          s_day  <= day_bin;
          s_mon  <= month_bin;
          s_year <= year_bin;
          s_page <= page_sel;
          s_bad  <= {month_bin > 4'd11, day_bin > 5'd30, hour_bin > 5'd23,
                     min_bin > 6'd59, sec_bin > 6'd59};
          dd_bin <= 15'(sec_bin);
          dd_bcd <= '0;
          field  <= '0;
          step   <= '0;
          busy   <= 1'b1;
          state  <= SHIFT;
        end
        LOAD: begin
          dd_bin <= load_val;
          dd_bcd <= '0;
          step   <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          dd_bcd <= bcd_next;
          dd_bin <= {dd_bin[13:0], 1'b0};
          step   <= step + 4'd1;
          if (step == 4'd14) begin
            case (field)
              3'd0:    stage_sec  <= bcd_next[7:0];
              3'd1:    stage_min  <= bcd_next[7:0];
              3'd2:    stage_hour <= bcd_next[7:0];
              3'd3:    stage_day  <= bcd_next[7:0];
              3'd4:    stage_mon  <= bcd_next[7:0];
              default: stage_year <= bcd_next[15:0];
            endcase
            if (field == 3'd5) begin
              state <= COMMIT;
            end else begin
              field <= field + 3'd1;
              state <= LOAD;
            end
          end
        end
        COMMIT: begin
          disp_sec  <= stage_sec;
          disp_min  <= stage_min;
          disp_hour <= stage_hour;
          disp_day  <= stage_day;
          disp_mon  <= stage_mon;
          disp_year <= stage_year;
          disp_bad  <= s_bad;
          disp_page <= s_page;
          valid     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_comb begin
    dig_en  = 1'b1;
    dig_val = '0;
    dig_bad = 1'b0;
    dig_dp  = 1'b0;
    if (!disp_page) begin
      case (digit)
        3'd0: begin dig_val = disp_sec[3:0];  dig_bad = disp_bad[0]; end
        3'd1: begin dig_val = disp_sec[7:4];  dig_bad = disp_bad[0]; end
        3'd2: begin dig_val = disp_min[3:0];  dig_bad = disp_bad[1]; dig_dp = 1'b1; end
        3'd3: begin dig_val = disp_min[7:4];  dig_bad = disp_bad[1]; end
        3'd4: begin dig_val = disp_hour[3:0]; dig_bad = disp_bad[2]; dig_dp = 1'b1; end
        3'd5: begin dig_val = disp_hour[7:4]; dig_bad = disp_bad[2]; end
        default: dig_en = 1'b0;
      endcase
    end else begin
      case (digit)
        3'd7: begin dig_val = disp_day[7:4]; dig_bad = disp_bad[3]; end
        3'd6: begin dig_val = disp_day[3:0]; dig_bad = disp_bad[3]; dig_dp = 1'b1; end
        3'd5: begin dig_val = disp_mon[7:4]; dig_bad = disp_bad[4]; end
        3'd4: begin dig_val = disp_mon[3:0]; dig_bad = disp_bad[4]; dig_dp = 1'b1; end
        3'd3: dig_val = disp_year[15:12];
        3'd2: dig_val = disp_year[11:8];
        3'd1: dig_val = disp_year[7:4];
        default: dig_val = disp_year[3:0];
      endcase
    end
    seg_next = dig_bad ? 7'h3F : glyph(dig_val);
  end

  // Scanner parks on digit 0 until the first commit so the first digit lights promptly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= '0;
      an_n     <= 8'hFF;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
    end else if (!valid) begin
      scan_cnt <= '0;
      digit    <= '0;
      an_n     <= 8'hFF;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      an_n  <= dig_en ? ~(8'd1 << digit) : 8'hFF;
      seg_n <= dig_en ? seg_next : 7'h7F;
      dp_n  <= dig_en ? ~dig_dp : 1'b1;
    end
  end

endmodule

// File: tb/tb_calendar_display_driver.sv
// Directed bench for calendar_display_driver with SCAN_DIV=4, UPD_DIV=256.
module tb_calendar_display_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  sec_bin = '0;
  logic [5:0]  min_bin = '0;
  logic [4:0]  hour_bin = '0;
  logic [4:0]  day_bin = '0;
  logic [3:0]  month_bin = '0;
  logic [13:0] year_bin = '0;
  logic        page_sel = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic        busy;

  calendar_display_driver #(.SCAN_DIV(4), .UPD_DIV(256), .YEAR_BASE(2024)) dut (
    .clk(clk), .rst_n(rst_n), .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
    .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin), .page_sel(page_sel),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] cap_seg [8];
  logic       cap_dp  [8];
  int         cap_cnt [8];
  int         cap_odd;

  typedef struct packed {
    logic [5:0] sec; logic [5:0] min; logic [4:0] hour; logic [5:0][6:0] seg;
  } tvec_t;
  typedef struct packed {
    logic [4:0] day; logic [3:0] mon; logic [13:0] year; logic [7:0][6:0] seg;
  } dvec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic capture();
    logic hit;
    logic [7:0] m;
    for (int d = 0; d < 8; d++) begin cap_cnt[d] = 0; cap_seg[d] = 7'h7F; cap_dp[d] = 1'b1; end
    cap_odd = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (an_n === 8'hFF) begin
        if (seg_n !== 7'h7F || dp_n !== 1'b1) cap_odd++;
      end else begin
        hit = 1'b0;
        for (int d = 0; d < 8; d++) begin
          m = ~(8'd1 << d);
          if (an_n === m) begin cap_cnt[d]++; cap_seg[d] = seg_n; cap_dp[d] = dp_n; hit = 1'b1; end
        end
        if (!hit) cap_odd++;
      end
    end
  endtask

  task automatic wait_busy(input logic level, input int bound, input string name);
    int n = 0;
    while (busy !== level && n < bound) begin @(negedge clk); n++; end
    n_vec++;
    if (busy !== level) begin
      $display("FAIL %s: busy=%b after %0d cycles, wanted %b", name, busy, n, level);
      n_err++;
    end
  endtask

  task automatic wait_commit(input string name);
    wait_busy(1'b1, 400, {name, "_rise"});
    wait_busy(1'b0, 150, {name, "_fall"});
  endtask

  task automatic test_reset();
    int bc, early, lat;
    rst_n = 1'b0; sec_bin = 6'd45; min_bin = 6'd7; hour_bin = 5'd23; page_sel = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (an_n !== 8'hFF) begin $display("FAIL reset_an: got %h want ff", an_n); n_err++; end
    n_vec++; if (seg_n !== 7'h7F) begin $display("FAIL reset_seg: got %h want 7f", seg_n); n_err++; end
    n_vec++; if (dp_n !== 1'b1) begin $display("FAIL reset_dp: got %b want 1", dp_n); n_err++; end
    n_vec++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_err++; end
    rst_n = 1'b1;
    @(negedge clk);
    bc = 0; early = 0;
    while (busy === 1'b1 && bc < 200) begin
      if (an_n !== 8'hFF) early++;
      bc++;
      @(negedge clk);
    end
    n_vec++; if (bc !== 96) begin $display("FAIL busy_len: got %0d want 96", bc); n_err++; end
    n_vec++; if (early !== 0) begin $display("FAIL dark_while_busy: lit %0d want 0", early); n_err++; end
    lat = 0;
    while (an_n !== 8'hFE && lat < 4) begin @(negedge clk); lat++; end
    n_vec++; if (an_n !== 8'hFE) begin $display("FAIL first_digit: got %h want fe", an_n); n_err++; end
  endtask

  task automatic test_time_page();
    tvec_t tv [4];
    logic lit;
    tv[0] = '{6'd45, 6'd7,  5'd23, {7'h24, 7'h30, 7'h40, 7'h78, 7'h19, 7'h12}};
    tv[1] = '{6'd60, 6'd7,  5'd24, {7'h3F, 7'h3F, 7'h40, 7'h78, 7'h3F, 7'h3F}};
    tv[2] = '{6'd59, 6'd59, 5'd0,  {7'h40, 7'h40, 7'h12, 7'h10, 7'h12, 7'h10}};
    tv[3] = '{6'd0,  6'd60, 5'd23, {7'h24, 7'h30, 7'h3F, 7'h3F, 7'h40, 7'h40}};
    for (int i = 0; i < 4; i++) begin
      sec_bin = tv[i].sec; min_bin = tv[i].min; hour_bin = tv[i].hour; page_sel = 1'b0;
      wait_commit("time_commit");
      capture();
      for (int d = 0; d < 8; d++) begin
        lit = (d < 6);
        n_vec++;
        if (cap_cnt[d] !== (lit ? 8 : 0)) begin
          $display("FAIL time[%0d] d%0d lit_cycles: got %0d want %0d", i, d, cap_cnt[d], lit ? 8 : 0); n_err++;
        end
        if (lit) begin
          n_vec++;
          if (cap_seg[d] !== tv[i].seg[d]) begin
            $display("FAIL time[%0d] d%0d seg: got %h want %h", i, d, cap_seg[d], tv[i].seg[d]); n_err++;
          end
          n_vec++;
          if (cap_dp[d] !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) begin
            $display("FAIL time[%0d] d%0d dp: got %b", i, d, cap_dp[d]); n_err++;
          end
        end
      end
      n_vec++; if (cap_odd !== 0) begin $display("FAIL time[%0d] scan_pattern: odd %0d want 0", i, cap_odd); n_err++; end
    end
  endtask

  task automatic test_date_page();
    dvec_t dv [4];
    dv[0] = '{5'd0,  4'd0,  14'd0,     {7'h40, 7'h79, 7'h40, 7'h79, 7'h24, 7'h40, 7'h24, 7'h19}};
    dv[1] = '{5'd0,  4'd0,  14'd16383, {7'h40, 7'h79, 7'h40, 7'h79, 7'h00, 7'h19, 7'h40, 7'h78}};
    dv[2] = '{5'd31, 4'd12, 14'd0,     {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h24, 7'h40, 7'h24, 7'h19}};
    dv[3] = '{5'd30, 4'd11, 14'd7975,  {7'h30, 7'h79, 7'h79, 7'h24, 7'h10, 7'h10, 7'h10, 7'h10}};
    for (int i = 0; i < 4; i++) begin
      day_bin = dv[i].day; month_bin = dv[i].mon; year_bin = dv[i].year; page_sel = 1'b1;
      wait_commit("date_commit");
      capture();
      for (int d = 0; d < 8; d++) begin
        n_vec++;
        if (cap_cnt[d] !== 8) begin
          $display("FAIL date[%0d] d%0d lit_cycles: got %0d want 8", i, d, cap_cnt[d]); n_err++;
        end
        n_vec++;
        if (cap_seg[d] !== dv[i].seg[d]) begin
          $display("FAIL date[%0d] d%0d seg: got %h want %h", i, d, cap_seg[d], dv[i].seg[d]); n_err++;
        end
        n_vec++;
        if (cap_dp[d] !== ((d == 6 || d == 4) ? 1'b0 : 1'b1)) begin
          $display("FAIL date[%0d] d%0d dp: got %b", i, d, cap_dp[d]); n_err++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0][6:0] exp_a, exp_b;
    exp_a = {7'h24, 7'h30, 7'h40, 7'h78, 7'h19, 7'h12};
    exp_b = {7'h40, 7'h12, 7'h30, 7'h19, 7'h79, 7'h24};
    sec_bin = 6'd45; min_bin = 6'd7; hour_bin = 5'd23; page_sel = 1'b0;
    wait_commit("b2b_a");
    wait_busy(1'b1, 400, "b2b_latch");
    sec_bin = 6'd12; min_bin = 6'd34; hour_bin = 5'd5; page_sel = 1'b1;
    wait_busy(1'b0, 150, "b2b_done");
    capture();
    for (int d = 0; d < 6; d++) begin
      n_vec++;
      if (cap_seg[d] !== exp_a[d]) begin
        $display("FAIL b2b_old d%0d seg: got %h want %h", d, cap_seg[d], exp_a[d]); n_err++;
      end
    end
    page_sel = 1'b0;
    wait_commit("b2b_b");
    capture();
    for (int d = 0; d < 6; d++) begin
      n_vec++;
      if (cap_seg[d] !== exp_b[d]) begin
        $display("FAIL b2b_new d%0d seg: got %h want %h", d, cap_seg[d], exp_b[d]); n_err++;
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int bc, early;
    logic [5:0][6:0] exp_b;
    exp_b = {7'h40, 7'h12, 7'h30, 7'h19, 7'h79, 7'h24};
    wait_busy(1'b1, 400, "mid_rise");
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (an_n !== 8'hFF) begin $display("FAIL mid_reset_an: got %h want ff", an_n); n_err++; end
    n_vec++; if (busy !== 1'b0) begin $display("FAIL mid_reset_busy: got %b want 0", busy); n_err++; end
    n_vec++; if (seg_n !== 7'h7F) begin $display("FAIL mid_reset_seg: got %h want 7f", seg_n); n_err++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bc = 0; early = 0;
    while (busy === 1'b1 && bc < 200) begin
      if (an_n !== 8'hFF) early++;
      bc++;
      @(negedge clk);
    end
    n_vec++; if (bc !== 96) begin $display("FAIL restart_busy_len: got %0d want 96", bc); n_err++; end
    n_vec++; if (early !== 0) begin $display("FAIL restart_dark: lit %0d want 0", early); n_err++; end
    capture();
    for (int d = 0; d < 6; d++) begin
      n_vec++;
      if (cap_seg[d] !== exp_b[d]) begin
        $display("FAIL restart d%0d seg: got %h want %h", d, cap_seg[d], exp_b[d]); n_err++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_time_page();
    test_date_page();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
